// File: rtl/iobus_pkg.sv
// Shared address map, CTRL/STATUS bit positions and FIFO entry sizing for the I/O bus slave.
package iobus_pkg;

  typedef logic [7:0] iob_addr_t;

  localparam iob_addr_t IOB_LEDS     = 8'h00;
  localparam iob_addr_t IOB_SWITCHES = 8'h04;
  localparam iob_addr_t IOB_VGAADDR  = 8'h08;
  localparam iob_addr_t IOB_VGADATA  = 8'h0C;
  localparam iob_addr_t IOB_SWEDGE   = 8'h10;
  localparam iob_addr_t IOB_STATUS   = 8'h14;
  localparam iob_addr_t IOB_CTRL     = 8'h18;

  localparam int CTRL_AUTOINC = 0;
  localparam int CTRL_IRQEN   = 1;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_SWEDGE  = 12;

  // A VGA FIFO entry is {address, 32-bit data}.
  function automatic int iob_fifo_width(input int rectbits);
    return rectbits + 1 + 32;
  endfunction

endpackage

// File: rtl/iobus_if.sv
// CPU stage-3/stage-4 I/O bus: strobes, address and write data in; read data and stall out.
interface iobus_if;
  import iobus_pkg::*;

  logic        rdstrobe_3a;
  logic        wrstrobe_3a;
  iob_addr_t   address_3a;
  logic [31:0] wrdata_3a;
  logic [31:0] rddata_4a;
  logic        stall_3a;

  modport master (
    output rdstrobe_3a, wrstrobe_3a, address_3a, wrdata_3a,
    input  rddata_4a, stall_3a
  );

  modport slave (
    input  rdstrobe_3a, wrstrobe_3a, address_3a, wrdata_3a,
    output rddata_4a, stall_3a
  );

endinterface

// File: rtl/iob_fifo.sv
// Synchronous FIFO of 2^LOG entries; head is combinational, push ignored when full, pop ignored when empty.
module iob_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG   = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LOG:0]     count_o
);

  localparam int DEPTH = 1 << LOG;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG-1:0]   wptr_q, rptr_q;
  logic [LOG:0]     cnt_q;
  logic             do_push, do_pop;

  assign full_o    = (cnt_q == (LOG+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rptr_q];

  // Storage carries no reset; an empty FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (LOG+1)'(do_push) - (LOG+1)'(do_pop);
    end
  end

endmodule

// File: rtl/iobus_ctl.sv
// I/O bus slave: LEDs, debounced switches with edge capture/irq, posted VGA writes.
// Reads return one cycle later; VGADATA writes stall combinationally while the FIFO is full.
module iobus_ctl
  import iobus_pkg::*;
#(
  parameter int NLEDS    = 8,
  parameter int NSW      = 8,
  parameter int RECTBITS = 6,
  parameter int FIFOLOG  = 2,
  parameter int DBBITS   = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  iobus_if.slave              bus,
  output logic [NLEDS-1:0]    leds,
  input  logic [NSW-1:0]      switches,
  output logic                irq,
  output logic [RECTBITS:0]   vg__addr,
  output logic [31:0]         vg__data,
  output logic                vg__write,
  input  logic                vg__ready
);

  localparam int AW = RECTBITS + 1;
  localparam int EW = iob_fifo_width(RECTBITS);

  logic [NLEDS-1:0]  leds_q, leds_d;
  logic [AW-1:0]     vgaaddr_q, vgaaddr_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [NSW-1:0]    swedge_q, swedge_d;
  logic [NSW-1:0]    sync1_q, sync2_q, samp_q, samp_d, db_q, db_d;
  logic [DBBITS-1:0] presc_q;
  logic [31:0]       rddata_q, rddata_d;

  logic              wr_vga, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFOLOG:0]  fifo_cnt;
  logic [EW-1:0]     fifo_head;
  logic              tick;
  logic [NSW-1:0]    db_chg, sw_clr;
  logic [31:0]       status;

  assign wr_vga       = bus.wrstrobe_3a && (bus.address_3a == IOB_VGADATA);
  assign bus.stall_3a = wr_vga && fifo_full;
  assign fifo_push    = wr_vga && !fifo_full;
  assign fifo_pop     = !fifo_empty && vg__ready;

  iob_fifo #(
    .WIDTH (EW),
    .LOG   (FIFOLOG)
  ) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push_i     (fifo_push),
    .push_dat_i ({vgaaddr_q, bus.wrdata_3a}),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign vg__write            = !fifo_empty;
  assign {vg__addr, vg__data} = fifo_empty ? '0 : fifo_head;

  // A bit only moves when two consecutive tick samples agree and differ from it.
  assign tick   = &presc_q;
  assign db_chg = tick ? (~(sync2_q ^ samp_q) & (sync2_q ^ db_q)) : '0;
  assign db_d   = db_q ^ db_chg;
  assign samp_d = tick ? sync2_q : samp_q;

  // Clear only what this read returns; a coincident edge survives.
  assign sw_clr   = (bus.rdstrobe_3a && (bus.address_3a == IOB_SWEDGE)) ? swedge_q : '0;
  assign swedge_d = (swedge_q & ~sw_clr) | db_chg;

  assign leds          = leds_q;
  assign irq           = ctrl_q[CTRL_IRQEN] && (|swedge_q);
  assign bus.rddata_4a = rddata_q;

  always_comb begin
    leds_d    = leds_q;
    vgaaddr_d = vgaaddr_q;
    ctrl_d    = ctrl_q;
    if (bus.wrstrobe_3a) begin
      case (bus.address_3a)
        IOB_LEDS:    leds_d    = bus.wrdata_3a[NLEDS-1:0];
        IOB_VGAADDR: vgaaddr_d = bus.wrdata_3a[AW-1:0];
        IOB_CTRL:    ctrl_d    = bus.wrdata_3a[1:0];
        default:     ;
      endcase
    end
    if (fifo_push && ctrl_q[CTRL_AUTOINC]) vgaaddr_d = vgaaddr_q + 1'b1;
  end

  always_comb begin
    status                         = '0;
    status[STAT_EMPTY]             = fifo_empty;
    status[STAT_FULL]              = fifo_full;
    status[STAT_CNT_LSB +: 5]      = 5'(fifo_cnt);
    status[STAT_SWEDGE]            = |swedge_q;
  end

  always_comb begin
    rddata_d = '0;
    case (bus.address_3a)
      IOB_LEDS:     rddata_d = 32'(leds_q);
      IOB_SWITCHES: rddata_d = 32'(db_q);
      IOB_VGAADDR:  rddata_d = 32'(vgaaddr_q);
      IOB_SWEDGE:   rddata_d = 32'(swedge_q);
      IOB_STATUS:   rddata_d = status;
      IOB_CTRL:     rddata_d = 32'(ctrl_q);
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      leds_q    <= '0;
      vgaaddr_q <= '0;
      ctrl_q    <= '0;
      swedge_q  <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      db_q      <= '0;
      presc_q   <= '0;
      rddata_q  <= '0;
    end else begin
      leds_q    <= leds_d;
      vgaaddr_q <= vgaaddr_d;
      ctrl_q    <= ctrl_d;
      swedge_q  <= swedge_d;
      sync1_q   <= switches;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      db_q      <= db_d;
      presc_q   <= presc_q + 1'b1;
      rddata_q  <= rddata_d;
    end
  end

endmodule
